// File: rtl/nor_pkg.sv
// Shared definitions for the nor2_11 gate-library cell.
// Holds the default width and the per-bit NOR helper.
package nor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Plain operators, so X/Z on an input bit
    // stays visible on that result bit.
    function automatic logic nor_f(
        input logic a,
        input logic b
    );
        return ~(a | b);
    endfunction

endpackage

// File: rtl/nor2_11_reg.sv
// Valid-qualified WIDTH-bit pipeline register, async active-low reset.
// Ports: clk, rst_n, in_valid, in_data -> out_data, out_valid.
module nor2_11_reg
    import nor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Data only loads on a valid beat; otherwise it
    // keeps the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (in_valid) begin
            out_data <= in_data;
        end
    end

endmodule

// File: rtl/nor2_11.sv
// Bitwise 2-input NOR: combinational result plus registered copy.
// Ports: clk, rst_n, in_valid, in_data1, in_data2 ->
//        out_data (comb), out_data_q, out_valid (registered).
module nor2_11
    import nor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_data_q,
    output logic             out_valid
);

    logic [WIDTH-1:0] nor_bits;

    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        assign nor_bits[k] = nor_f(in_data1[k], in_data2[k]);
    end

    assign out_data = nor_bits;

    nor2_11_reg #(
        .WIDTH(WIDTH)
    ) u_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (nor_bits),
        .out_data (out_data_q),
        .out_valid(out_valid)
    );

endmodule

// File: tb/tb_nor2_11.sv
// Directed bench for nor2_11 at WIDTH 4, 1 and 16.
// Expected values are constants or computed locally.
module tb_nor2_11;

    logic clk;
    logic rst_n;

    logic        v4, v1, v16;
    logic [3:0]  a4, b4, o4, q4;
    logic [0:0]  a1, b1, o1, q1;
    logic [15:0] a16, b16, o16, q16;
    logic        ov4, ov1, ov16;

    int vectors;
    int miscompares;

    nor2_11 #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4),
        .in_data1(a4), .in_data2(b4),
        .out_data(o4), .out_data_q(q4), .out_valid(ov4)
    );

    nor2_11 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1),
        .in_data1(a1), .in_data2(b1),
        .out_data(o1), .out_data_q(q1), .out_valid(ov1)
    );

    nor2_11 #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16),
        .in_data1(a16), .in_data2(b16),
        .out_data(o16), .out_data_q(q16), .out_valid(ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [15:0] got,
        input logic [15:0] exp
    );
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        v4 = 0; v1 = 0; v16 = 0;
        a4 = 0; b4 = 0; a1 = 0; b1 = 0; a16 = 0; b16 = 0;
        #1;
        check("rst_q4", q4, 16'h0);
        check("rst_v4", {15'h0, ov4}, 16'h0);
        check("rst_q16", q16, 16'h0);
        check("rst_v16", {15'h0, ov16}, 16'h0);
        check("rst_comb4", o4, 16'hF);

        @(negedge clk);
        rst_n = 1'b1;

        // exhaustive comb sweep, WIDTH=4
        for (int i = 0; i < 256; i++) begin
            logic [7:0] p;
            logic [3:0] e;
            p  = i[7:0];
            a4 = p[7:4];
            b4 = p[3:0];
            e  = ~(p[7:4] | p[3:0]);
            #1;
            check("sweep4", {12'h0, o4}, {12'h0, e});
        end

        a4 = 4'h0; b4 = 4'h0; #1; check("c00", o4, 16'hF);
        a4 = 4'hF; b4 = 4'h0; #1; check("cF0", o4, 16'h0);
        a4 = 4'h5; b4 = 4'hA; #1; check("c5A", o4, 16'h0);
        a4 = 4'h1; b4 = 4'h2; #1; check("c12", o4, 16'hC);

        // WIDTH=1 exhaustive + random
        for (int i = 0; i < 4; i++) begin
            logic [1:0] p;
            p = i[1:0];
            a1 = p[1]; b1 = p[0];
            #1;
            check("w1_ex", {15'h0, o1}, {15'h0, ~(p[1] | p[0])});
        end
        for (int i = 0; i < 32; i++) begin
            logic [1:0] r;
            r = 2'($urandom);
            a1 = r[1]; b1 = r[0];
            #1;
            check("w1_rnd", {15'h0, o1}, {15'h0, ~(r[1] | r[0])});
        end

        // WIDTH=16 random + corner
        for (int i = 0; i < 64; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            a16 = ra; b16 = rb;
            #1;
            check("w16_rnd", o16, ~(ra | rb));
        end
        a16 = 16'h00FF; b16 = 16'h0F00; #1;
        check("w16_corner", o16, 16'hF000);
        a16 = 16'h0000; b16 = 16'h0000; #1;
        check("w16_zero", o16, 16'hFFFF);
        a16 = 16'hFFFF; b16 = 16'hFFFF; #1;
        check("w16_ones", o16, 16'h0000);

        // registered path
        @(negedge clk);
        v4 = 1; a4 = 4'h3; b4 = 4'h4;
        tick();
        check("reg_q", q4, 16'h8);
        check("reg_v", {15'h0, ov4}, 16'h1);
        @(negedge clk);
        v4 = 0; a4 = 4'hF; b4 = 4'hF;
        tick();
        check("hold_v", {15'h0, ov4}, 16'h0);
        check("hold_q", q4, 16'h8);

        // async reset mid-stream
        @(negedge clk);
        v4 = 1; a4 = 4'h0; b4 = 4'h1;
        tick();
        check("pre_rst_q", q4, 16'hE);
        check("pre_rst_v", {15'h0, ov4}, 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q", q4, 16'h0);
        check("arst_v", {15'h0, ov4}, 16'h0);
        a4 = 4'h1; b4 = 4'h2; #1;
        check("rst_comb", o4, 16'hC);
        tick();
        check("rst_held_v", {15'h0, ov4}, 16'h0);
        check("rst_held_q", q4, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        v4 = 0;

        // back-to-back valids
        @(negedge clk);
        v4 = 1; a4 = 4'h0; b4 = 4'h0;
        tick();
        check("b2b0_q", q4, 16'hF);
        check("b2b0_v", {15'h0, ov4}, 16'h1);
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF;
        tick();
        check("b2b1_q", q4, 16'h0);
        check("b2b1_v", {15'h0, ov4}, 16'h1);
        @(negedge clk);
        a4 = 4'h6; b4 = 4'h1;
        tick();
        check("b2b2_q", q4, 16'h8);
        check("b2b2_v", {15'h0, ov4}, 16'h1);
        @(negedge clk);
        v4 = 0;
        tick();
        check("b2b_end_v", {15'h0, ov4}, 16'h0);

        // registered path at other widths
        @(negedge clk);
        v16 = 1; a16 = 16'h00FF; b16 = 16'h0F00;
        v1 = 1; a1 = 1'b0; b1 = 1'b0;
        tick();
        check("w16_q", q16, 16'hF000);
        check("w16_v", {15'h0, ov16}, 16'h1);
        check("w1_q", {15'h0, q1}, 16'h1);
        check("w1_v", {15'h0, ov1}, 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
